// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default bundle widths, per-stage kill masks
// and the skid-buffer state encoding.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_DATA_W = 64;

    // Bit positions of the side-effecting enables inside the control bundle.
    localparam int REG_WRITE = 0;
    localparam int MEM_READ  = 1;
    localparam int MEM_WRITE = 2;
    localparam int HALT      = 3;

    localparam logic [PIPE_CTRL_W-1:0] ID_EX_KILL_MASK  = {PIPE_CTRL_W{1'b1}};
    localparam logic [PIPE_CTRL_W-1:0] EX_MEM_KILL_MASK =
        PIPE_CTRL_W'((1 << REG_WRITE) | (1 << MEM_READ) | (1 << MEM_WRITE) | (1 << HALT));

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+ctrl+data storage entry. Load wins over clear; ctrl/data change only on load.
module pipe_entry_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    // NOTE: payload flops are reset too, so out_ctrl/out_data read 0 during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush and bubble kill mask.
// Optional performance counters are enabled with `define PIPE_STAGE_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                CTRL_W    = PIPE_CTRL_W,
    parameter int                DATA_W    = PIPE_DATA_W,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
    logic [DATA_W-1:0] m_data, s_data, m_data_d;
    logic              m_load, m_clr, m_from_skid, s_load, s_clr;
    logic              in_ready_q, in_ready_d;
    logic              accept, drain;
    pipe_skid_state_t  state, state_d;

    assign accept = in_valid & in_ready_q;
    assign drain  = m_valid & out_ready;

    // The entry valid bits are the state register; decode them into the named state.
    always_comb begin
        case ({s_valid, m_valid})
            2'b01:   state = HALF;
            2'b11:   state = FULL;
            default: state = EMPTY;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        m_load      = 1'b0;
        m_clr       = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clr       = 1'b0;
        state_d     = state;
        if (flush) begin
            m_clr   = 1'b1;
            s_clr   = 1'b1;
            state_d = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    m_load  = 1'b1;
                    state_d = HALF;
                end
                HALF: if (accept && drain) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    s_load  = 1'b1;
                    state_d = FULL;
                end else if (drain) begin
                    m_clr   = 1'b1;
                    state_d = EMPTY;
                end
                FULL: if (drain) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    s_clr       = 1'b1;
                    state_d     = HALF;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign m_ctrl_d   = m_from_skid ? s_ctrl : in_ctrl;
    assign m_data_d   = m_from_skid ? s_data : in_data;
    assign in_ready_d = (state_d != FULL);

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (m_load),
        .clear_i (m_clr),
        .ctrl_i  (m_ctrl_d),
        .data_i  (m_data_d),
        .valid_o (m_valid),
        .ctrl_o  (m_ctrl),
        .data_o  (m_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s_load),
        .clear_i (s_clr),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (s_valid),
        .ctrl_o  (s_ctrl),
        .data_o  (s_data)
    );

    // Held at 0 in reset so upstream cannot hand over a beat until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b0;
        else      in_ready_q <= in_ready_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl & ~(KILL_MASK & {CTRL_W{!m_valid}});
    assign out_data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_valid && !out_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && (m_valid || s_valid) && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
    a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst) !(s_valid && !m_valid))
        else $error("skid entry valid while main entry empty");
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers.
- Carries an arbitrary control bundle and data bundle between two pipeline stages using a valid/ready handshake.
- A two-entry skid buffer gives full throughput under backpressure and a registered in_ready.
- Supports flush (squash) and bubble insertion: selected control bits are forced to 0 whenever no valid instruction is presented, so Reg_write/Mem_write-style enables can never leak from a bubble.

Parameters:
- CTRL_W, 16, width of control bundle (ALU op, write enables, mem enables, halt, ...).
- DATA_W, 64, width of data bundle (instruction, immediate, operands, register numbers).
- KILL_MASK, {CTRL_W{1'b1}}, per-bit mask of control bits forced to 0 on out_ctrl while out_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a beat.
- in_ready  out  1  stage can accept a beat; registered (no combinational path from out_ready).
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  squash all held beats this cycle.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main-entry control; KILL_MASK bits are 0 when out_valid=0.
- out_data  out  DATA_W  main-entry data.

Behaviour:
- Storage: a main entry (m_valid, m_ctrl, m_data) driving the outputs, plus a skid entry (s_valid, s_ctrl, s_data).
- in_ready = !s_valid. out_valid = m_valid.
- out_ctrl = m_ctrl & ~(KILL_MASK & {CTRL_W{!m_valid}}).
- Handshake terms: accept = in_valid & in_ready; drain = out_valid & out_ready.
- State (m_valid, s_valid):
  - EMPTY (0,0): accept -> HALF, beat loads main.
  - HALF (1,0):
    - accept & drain -> HALF, main reloads with the new beat.
    - accept & !drain -> FULL, beat loads skid.
    - !accept & drain -> EMPTY.
    - otherwise hold.
  - FULL (1,1): in_ready=0.
    - drain -> HALF, skid moves to main and skid clears.
    - otherwise hold.
- (0,1) is illegal. It is unreachable; an assertion flags it.
- Latency: one cycle from accept to out_valid when empty. Sustains 1 beat/cycle while out_ready=1.
- Ordering: beats leave in strict acceptance order. No beat is dropped or duplicated.
- Flush:
  - Synchronous; clears m_valid and s_valid at the next edge.
  - Highest priority: a beat accepted in the flush cycle is discarded.
  - A drain in the flush cycle still completes (downstream has already sampled it).
  - ctrl/data registers keep stale values, but the kill mask hides ctrl.
- Stall: out_ready=0 holds the main entry unchanged (this replaces the per-field stall muxing used in earlier designs).
- Data/ctrl registers load only on transfer, with no enable toggling otherwise.
- Reset:
  - While rst=0: all state registers are 0, out_valid=0, out_ctrl=0, out_data=0.
  - in_ready is forced to 0 while rst=0 and rises on the first clk after release.
  - Reset asserted mid-operation discards all beats immediately (asynchronous).

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while any entry is valid.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and counter logic are absent. Handshake behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg:
  - Default widths PIPE_CTRL_W and PIPE_DATA_W.
  - Per-stage KILL_MASK constants (ID_EX_KILL_MASK, EX_MEM_KILL_MASK), with bit-index localparams for REG_WRITE, MEM_READ, MEM_WRITE and HALT.
  - State encoding typedef pipe_skid_state_t {EMPTY, HALF, FULL}.
- Sub-module pipe_entry_reg: one valid+ctrl+data entry with asynchronous active-low reset and load/clear inputs, instantiated twice (main, skid).

Test Plan:
1. Reset: hold rst=0 with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0. Release -> in_ready=1 on the next clk.
2. Streaming: out_ready=1, in_valid=1 for 8 cycles, data 0..7 -> out_data 0..7 on consecutive cycles starting 1 cycle later; in_ready stays 1.
3. Backpressure: accept beats 0xA, 0xB, 0xC while out_ready drops to 0 after 0xA is presented -> FULL holding 0xA/0xB, in_ready=0, 0xC is held upstream. Raise out_ready -> 0xA, 0xB, 0xC are delivered in order.
4. Flush in FULL with a simultaneous in_valid (beat 0xD) -> next cycle out_valid=0, in_ready=1, 0xD is never output; out_ctrl & KILL_MASK = 0.
5. Bubble mask: KILL_MASK=16'h00F0, m_ctrl=16'hFFFF, then flush -> out_ctrl=16'hFF0F while out_valid=0.
6. PIPE_STAGE_PERF_EN: 5 stalled cycles, then 1 flush with a held beat -> stall_cnt=5, flush_cnt=1. A flush while EMPTY does not increment flush_cnt.
